// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32IM decode for the 32-bit ALU, registered into the
// ID/EX pipeline register with flush and stall handling. The decode is purely
// combinational. Every output comes straight from the register.
module alu_issue_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  input  logic [31:0] INSTR,
  input  logic [31:0] PC,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  output logic [4:0]  ALUOP,
  output logic        ASEL,
  output logic [1:0]  BSEL,
  output logic [31:0] IMM,
  output logic [3:0]  BRANCH,
  output logic        JUMP,
  output logic        REG_WRITE,
  output logic [4:0]  RD,
  output logic        ILLEGAL,
  output logic [31:0] PC_OUT
);

  typedef enum logic [4:0] {
    ALU_FWD    = 5'b00000,
    ALU_ADD    = 5'b00001,
    ALU_SUB    = 5'b00010,
    ALU_SLL    = 5'b00011,
    ALU_SLT    = 5'b00100,
    ALU_SLTU   = 5'b00101,
    ALU_XOR    = 5'b00110,
    ALU_SRL    = 5'b00111,
    ALU_SRA    = 5'b01000,
    ALU_OR     = 5'b01001,
    ALU_AND    = 5'b01010,
    ALU_MUL    = 5'b01011,
    ALU_MULH   = 5'b01100,
    ALU_MULHSU = 5'b01101,
    ALU_MULHU  = 5'b01110,
    ALU_DIV    = 5'b01111,
    ALU_DIVU   = 5'b10000,
    ALU_REM    = 5'b10001,
    ALU_REMU   = 5'b10010
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  localparam logic [1:0] BSEL_RS2  = 2'b00;
  localparam logic [1:0] BSEL_IMM  = 2'b01;
  localparam logic [1:0] BSEL_FOUR = 2'b10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // Contents of the ID/EX register. Its field order matches the port list.
  typedef struct packed {
    logic        valid;
    alu_op_e     aluop;
    logic        asel;
    logic [1:0]  bsel;
    logic [31:0] imm;
    logic [3:0]  branch;
    logic        jump;
    logic        reg_write;
    logic [4:0]  rd;
    logic        illegal;
    logic [31:0] pc;
  } id_ex_t;

  id_ex_t id_ex_q, id_ex_d, dec;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode   = INSTR[6:0];
  assign funct3   = INSTR[14:12];
  assign funct7   = INSTR[31:25];
  assign rd_field = INSTR[11:7];

  assign imm_i  = {{20{INSTR[31]}}, INSTR[31:20]};
  assign imm_s  = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
  assign imm_b  = {{19{INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
  assign imm_u  = {INSTR[31:12], 12'b0};
  assign imm_j  = {{11{INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};
  // The ALU shifts by the whole of operand B, so the shamt is zero-extended.
  assign imm_sh = {27'b0, INSTR[24:20]};

  logic illegal;
  logic writes_rd;

  // Decode the instruction into the ALU controls, with illegal encodings detected.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path through the
    // case that did not assign one would otherwise infer a latch.
    dec       = '0;
    illegal   = 1'b0;
    writes_rd = 1'b0;

    case (opcode)
      OPC_LUI: begin
        dec.aluop = ALU_FWD;
        dec.bsel  = BSEL_IMM;
        dec.imm   = imm_u;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.aluop = ALU_ADD;
        dec.asel  = 1'b1;
        dec.bsel  = BSEL_IMM;
        dec.imm   = imm_u;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dec.aluop = ALU_ADD;
        dec.asel  = 1'b1;
        dec.bsel  = BSEL_FOUR;
        dec.jump  = 1'b1;
        dec.imm   = imm_j;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.aluop = ALU_ADD;
        dec.asel  = 1'b1;
        dec.bsel  = BSEL_FOUR;
        dec.jump  = 1'b1;
        dec.imm   = imm_i;
        writes_rd = 1'b1;
        illegal   = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.aluop  = ALU_SUB;
        dec.bsel   = BSEL_RS2;
        dec.branch = {1'b1, funct3};
        dec.imm    = imm_b;
        illegal    = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.aluop = ALU_ADD;
        dec.bsel  = BSEL_IMM;
        dec.imm   = imm_i;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        dec.aluop = ALU_ADD;
        dec.bsel  = BSEL_IMM;
        dec.imm   = imm_s;
      end
      OPC_OP_IMM: begin
        dec.bsel  = BSEL_IMM;
        dec.imm   = imm_i;
        writes_rd = 1'b1;
        case (funct3)
          3'b000: dec.aluop = ALU_ADD;
          3'b010: dec.aluop = ALU_SLT;
          3'b011: dec.aluop = ALU_SLTU;
          3'b100: dec.aluop = ALU_XOR;
          3'b110: dec.aluop = ALU_OR;
          3'b111: dec.aluop = ALU_AND;
          3'b001: begin
            dec.aluop = ALU_SLL;
            dec.imm   = imm_sh;
            illegal   = (funct7 != F7_BASE);
          end
          default: begin // 3'b101
            dec.imm = imm_sh;
            if (funct7 == F7_BASE)     dec.aluop = ALU_SRL;
            else if (funct7 == F7_ALT) dec.aluop = ALU_SRA;
            else                       illegal   = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.bsel  = BSEL_RS2;
        writes_rd = 1'b1;
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  dec.aluop = ALU_ADD;
              3'b001:  dec.aluop = ALU_SLL;
              3'b010:  dec.aluop = ALU_SLT;
              3'b011:  dec.aluop = ALU_SLTU;
              3'b100:  dec.aluop = ALU_XOR;
              3'b101:  dec.aluop = ALU_SRL;
              3'b110:  dec.aluop = ALU_OR;
              default: dec.aluop = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      dec.aluop = ALU_SUB;
            else if (funct3 == 3'b101) dec.aluop = ALU_SRA;
            else                       illegal   = 1'b1;
          end
          F7_MULD: dec.aluop = alu_op_e'(5'(ALU_MUL) + {2'b00, funct3});
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // An illegal instruction still travels to EX as a valid slot, so that EX
    // can raise the exception. It carries no side effects.
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec.rd        = writes_rd ? rd_field : 5'd0;
      dec.reg_write = writes_rd && (rd_field != 5'd0);
    end
    dec.valid = 1'b1;
    dec.pc    = PC;
  end

  // Next-state priority of the ID/EX register: flush, then stall, then load.
  always_comb begin
    if (FLUSH)         id_ex_d = '0;
    else if (STALL)    id_ex_d = id_ex_q;
    else if (IN_VALID) id_ex_d = dec;
    else               id_ex_d = '0;
  end

  // ID/EX register. Reset is synchronous and overrides everything else.
  always_ff @(posedge CLK) begin
    // NOTE: use non-blocking assignments for state. Every flop then samples
    // its pre-edge value, whatever order the blocks are evaluated in.
    if (RESET) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign OUT_VALID = id_ex_q.valid;
  assign ALUOP     = id_ex_q.aluop;
  assign ASEL      = id_ex_q.asel;
  assign BSEL      = id_ex_q.bsel;
  assign IMM       = id_ex_q.imm;
  assign BRANCH    = id_ex_q.branch;
  assign JUMP      = id_ex_q.jump;
  assign REG_WRITE = id_ex_q.reg_write;
  assign RD        = id_ex_q.rd;
  assign ILLEGAL   = id_ex_q.illegal;
  assign PC_OUT    = id_ex_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. The expected values are hand-decoded
// RV32IM encodings.
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, STALL, FLUSH;
  logic [31:0] INSTR, PC;
  logic        OUT_VALID, ASEL, JUMP, REG_WRITE, ILLEGAL;
  logic [4:0]  ALUOP, RD;
  logic [1:0]  BSEL;
  logic [31:0] IMM, PC_OUT;
  logic [3:0]  BRANCH;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SRAI  = 32'h40435293; // srai x5,x6,4
  localparam logic [31:0] I_BLT   = 32'hFE20CCE3; // blt  x1,x2,-8
  localparam logic [31:0] I_DIVU  = 32'h029453B3; // divu x7,x8,x9
  localparam logic [31:0] I_LUI   = 32'h123450B7; // lui  x1,0x12345
  localparam logic [31:0] I_JAL   = 32'h008000EF; // jal  x1,+8
  localparam logic [31:0] I_SW    = 32'h0020A623; // sw   x2,12(x1)
  localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_ADDIM = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_BR010 = 32'h0020A063; // branch with funct3 010
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;

  alu_issue_stage dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .INSTR(INSTR), .PC(PC),
    .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .ALUOP(ALUOP),
    .ASEL(ASEL), .BSEL(BSEL), .IMM(IMM), .BRANCH(BRANCH), .JUMP(JUMP),
    .REG_WRITE(REG_WRITE), .RD(RD), .ILLEGAL(ILLEGAL), .PC_OUT(PC_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply inputs, clock one edge, then settle just past it before sampling.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic stall, input logic flush);
    RESET = rst; IN_VALID = v; INSTR = instr; PC = pc; STALL = stall; FLUSH = flush;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(OUT_VALID), 32'd0);
    check({tag, "_aluop"}, 32'(ALUOP), 32'd0);
    check({tag, "_ctl"}, {21'd0, ASEL, BSEL, BRANCH, JUMP, REG_WRITE, ILLEGAL}, 32'd0);
    check({tag, "_imm"}, IMM, 32'd0);
    check({tag, "_rd"}, 32'(RD), 32'd0);
    check({tag, "_pc"}, PC_OUT, 32'd0);
  endtask

  task automatic check_add(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_aluop"}, 32'(ALUOP), 32'b00001);
    check({tag, "_asel"}, 32'(ASEL), 32'd0);
    check({tag, "_bsel"}, 32'(BSEL), 32'b00);
    check({tag, "_rd"}, 32'(RD), 32'd3);
    check({tag, "_wb"}, 32'(REG_WRITE), 32'd1);
    check({tag, "_ill"}, 32'(ILLEGAL), 32'd0);
    check({tag, "_pc"}, PC_OUT, pc);
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; INSTR = '0; PC = '0; STALL = 1'b0; FLUSH = 1'b0;

    // A valid instruction presented during reset must not load.
    cycle(1, 1, I_ADD, 32'h100, 0, 0);
    check_zero("reset");

    cycle(0, 1, I_ADD, 32'h100, 0, 0);
    check_add("add", 32'h100);

    cycle(0, 1, I_SRAI, 32'h104, 0, 0);
    check("srai_aluop", 32'(ALUOP), 32'b01000);
    check("srai_bsel", 32'(BSEL), 32'b01);
    check("srai_imm", IMM, 32'h00000004);
    check("srai_rd", 32'(RD), 32'd5);
    check("srai_wb", 32'(REG_WRITE), 32'd1);

    cycle(0, 1, I_BLT, 32'h108, 0, 0);
    check("blt_aluop", 32'(ALUOP), 32'b00010);
    check("blt_branch", 32'(BRANCH), 32'b1100);
    check("blt_imm", IMM, 32'hFFFFFFF8);
    check("blt_wb", 32'(REG_WRITE), 32'd0);
    check("blt_bsel", 32'(BSEL), 32'b00);

    cycle(0, 1, I_DIVU, 32'h10C, 0, 0);
    check("divu_aluop", 32'(ALUOP), 32'b10000);
    check("divu_bsel", 32'(BSEL), 32'b00);
    check("divu_rd", 32'(RD), 32'd7);
    check("divu_pc", PC_OUT, 32'h10C);

    cycle(0, 1, I_LUI, 32'h110, 0, 0);
    check("lui_aluop", 32'(ALUOP), 32'b00000);
    check("lui_bsel", 32'(BSEL), 32'b01);
    check("lui_imm", IMM, 32'h12345000);
    check("lui_wb", 32'(REG_WRITE), 32'd1);

    cycle(0, 1, I_JAL, 32'h114, 0, 0);
    check("jal_aluop", 32'(ALUOP), 32'b00001);
    check("jal_asel", 32'(ASEL), 32'd1);
    check("jal_bsel", 32'(BSEL), 32'b10);
    check("jal_jump", 32'(JUMP), 32'd1);
    check("jal_imm", IMM, 32'h00000008);
    check("jal_rd", 32'(RD), 32'd1);

    cycle(0, 1, I_SW, 32'h118, 0, 0);
    check("sw_aluop", 32'(ALUOP), 32'b00001);
    check("sw_imm", IMM, 32'h0000000C);
    check("sw_wb", 32'(REG_WRITE), 32'd0);

    // Destination x0 must never be written.
    cycle(0, 1, I_NOP, 32'h11C, 0, 0);
    check("nop_wb", 32'(REG_WRITE), 32'd0);
    check("nop_valid", 32'(OUT_VALID), 32'd1);

    cycle(0, 1, I_ADDIM, 32'h120, 0, 0);
    check("addi_imm", IMM, 32'hFFFFFFFF);
    check("addi_wb", 32'(REG_WRITE), 32'd1);

    cycle(0, 1, I_BR010, 32'h124, 0, 0);
    check("br010_ill", 32'(ILLEGAL), 32'd1);
    check("br010_branch", 32'(BRANCH), 32'd0);

    cycle(0, 1, I_ONES, 32'h128, 0, 0);
    check("ones_ill", 32'(ILLEGAL), 32'd1);
    check("ones_valid", 32'(OUT_VALID), 32'd1);
    check("ones_wb", 32'(REG_WRITE), 32'd0);
    check("ones_aluop", 32'(ALUOP), 32'd0);
    check("ones_pc", PC_OUT, 32'h128);

    // Without IN_VALID the register loads a bubble.
    cycle(0, 0, I_ADD, 32'h12C, 0, 0);
    check_zero("bubble");

    // The outputs hold ADD while STALL is high, even with DIVU driven.
    cycle(0, 1, I_ADD, 32'h200, 0, 0);
    check_add("pre_stall", 32'h200);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, I_DIVU, 32'h204, 1, 0);
      check_add($sformatf("stall%0d", k), 32'h200);
    end
    cycle(0, 1, I_DIVU, 32'h204, 1, 1);
    check_zero("flush");
    cycle(0, 1, I_DIVU, 32'h204, 0, 0);
    check("post_flush_aluop", 32'(ALUOP), 32'b10000);
    check("post_flush_rd", 32'(RD), 32'd7);
    check("post_flush_valid", 32'(OUT_VALID), 32'd1);

    // A mid-stream reset clears the register on its own edge. The first load
    // comes on the next edge.
    cycle(0, 1, I_ADD, 32'h300, 0, 0);
    check_add("pre_reset", 32'h300);
    cycle(1, 1, I_ADD, 32'h304, 1, 0);
    check_zero("mid_reset");
    cycle(0, 1, I_ADD, 32'h308, 0, 0);
    check_add("post_reset", 32'h308);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
